// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with a pending-write scoreboard.
// Requesters are granted combinationally, alternating under contention.
// The winning write is issued to the register file one cycle after the transfer.
// A per-register busy bitmap tracks outstanding writes for hazard checks elsewhere.
module rf_wb_arbiter #(
    parameter int unsigned SB_EN = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    input  logic [4:0]  req0_wa,
    input  logic [31:0] req0_wd,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [4:0]  req1_wa,
    input  logic [31:0] req1_wd,
    output logic        req1_ready,

    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,

    input  logic        sb_set,
    input  logic [4:0]  sb_addr,
    output logic [31:0] busy
);

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;

    // prio names the requester that wins when both are valid
    logic          prio;
    logic          xfer0_c;
    logic          xfer1_c;
    logic          xfer_c;
    logic [AW-1:0] sel_wa_c;
    logic [DW-1:0] sel_wd_c;

    // Grant: lone requester wins, contention resolved by prio, nothing during reset
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || !prio)) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
    end

    // Transfer detection and write-payload selection
    always_comb begin
        xfer0_c  = req0_valid && req0_ready;
        xfer1_c  = req1_valid && req1_ready;
        xfer_c   = xfer0_c || xfer1_c;
        sel_wa_c = xfer1_c ? req1_wa : req0_wa;
        sel_wd_c = xfer1_c ? req1_wd : req0_wd;
    end

    // Priority hands the next contention to whoever just lost
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (xfer0_c) begin
            prio <= 1'b1;
        end else if (xfer1_c) begin
            prio <= 1'b0;
        end
    end

    // Registered write command; writes to x0 are accepted but never enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (xfer_c) begin
            rf_we <= (sel_wa_c != '0);
            rf_wa <= sel_wa_c;
            rf_wd <= sel_wd_c;
        end else begin
            rf_we <= 1'b0;
        end
    end

    generate
        if (SB_EN != 0) begin : g_sb
            logic [NREG-1:0] busy_q;
            logic [NREG-1:0] set_mask_c;
            logic [NREG-1:0] clr_mask_c;

            // One-hot set/clear masks; x0 is never reserved
            always_comb begin
                set_mask_c = '0;
                clr_mask_c = '0;
                if (sb_set && (sb_addr != '0)) begin
                    set_mask_c[sb_addr] = 1'b1;
                end
                if (rf_we) begin
                    clr_mask_c[rf_wa] = 1'b1;
                end
            end

            // Clear first then set, so a same-register collision stays busy
            always_ff @(posedge clk) begin
                if (rst) begin
                    busy_q <= '0;
                end else begin
                    busy_q <= ((busy_q & ~clr_mask_c) | set_mask_c) & ~NREG'(1);
                end
            end

            assign busy = busy_q;
        end else begin : g_no_sb
            logic unused_sb;
            assign unused_sb = ^{sb_set, sb_addr};
            assign busy      = '0;
        end
    endgenerate

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a reference model predicts grants and the
// post-edge register-file command and busy map; a monitor checks them after each edge.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_wa, req1_wa;
    logic [31:0] req0_wd, req1_wd;
    logic        req0_ready, req1_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [31:0] busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] busy;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.SB_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_wa    (req0_wa),
        .req0_wd    (req0_wd),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_wa    (req1_wa),
        .req1_wd    (req1_wd),
        .req1_ready (req1_ready),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model state: who should win next, last command, outstanding registers
    logic        m_prio;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [31:0] m_busy;

    // Model: check grants mid-cycle, then predict the state after the coming edge
    always @(negedge clk) begin
        logic        e0, e1;
        logic [31:0] nb;
        exp_t        it;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                e0 = (m_prio == 1'b0);
                e1 = (m_prio == 1'b1);
            end else begin
                e0 = req0_valid;
                e1 = req1_valid;
            end
        end
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
        if (rst) begin
            m_prio = 1'b0;
            m_we   = 1'b0;
            m_wa   = 5'd0;
            m_wd   = 32'd0;
            m_busy = 32'd0;
        end else begin
            nb = m_busy;
            if (m_we) nb[m_wa] = 1'b0;
            if (sb_set && sb_addr != 5'd0) nb[sb_addr] = 1'b1;
            if (e0) begin
                m_we = (req0_wa != 5'd0); m_wa = req0_wa; m_wd = req0_wd; m_prio = 1'b1;
            end else if (e1) begin
                m_we = (req1_wa != 5'd0); m_wa = req1_wa; m_wd = req1_wd; m_prio = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            m_busy = nb;
        end
        it.we   = m_we;
        it.wa   = m_wa;
        it.wd   = m_wd;
        it.busy = m_busy;
        exp_q.push_back(it);
    end

    // Monitor: compare registered outputs just after each rising edge
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we", 32'(rf_we), 32'(e.we));
            chk("rf_wa", 32'(rf_wa), 32'(e.wa));
            chk("rf_wd", rf_wd, e.wd);
            chk("busy",  busy,  e.busy);
        end
    end

    task automatic drive(input logic r,
                         input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic s,  input logic [4:0] sa);
        rst = r;
        req0_valid = v0; req0_wa = a0; req0_wd = d0;
        req1_valid = v1; req1_wa = a1; req1_wd = d1;
        sb_set = s; sb_addr = sa;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        drive(1'b1, 1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, 1'b0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        // Single requester
        drive(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        idle();
        // Contention right after reset: 0,1,0,1
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, 5'd3, 32'hA0 + 32'(i), 1'b1, 5'd4, 32'hB0 + 32'(i), 1'b0, 5'd0);
        idle();
        // Write to x0 from requester 1
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
        idle();
        // Scoreboard set then clear of register 7
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        idle();
        drive(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        idle();
        idle();
        // Set/clear collision on register 9; also an ignored set of x0
        drive(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        idle();
        // Build busy = 0xF00, then reset while a write is in flight
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC12, 1'b0, 5'd0);
        drive(1'b1, 1'b1, 5'd3, 32'd3, 1'b1, 5'd4, 32'd4, 1'b1, 5'd13);
        drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
        drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
        idle();
        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
        end
        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
